// File: rtl/noc_local_ingress_unit.sv
// Local-port ingress stage of a mesh router: buffers node flits, XY-routes each
// header, and holds that route until the packet's tail has been forwarded.
module noc_local_ingress_unit #(
  parameter int X_ID      = 0,
  parameter int Y_ID      = 0,
  parameter int FLIT_W    = 64,
  parameter int ID_X_W    = 4,
  parameter int ID_Y_W    = 4,
  parameter int DST_X_LSB = 44,
  parameter int DST_Y_LSB = 40,
  parameter int DEPTH     = 4
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_is_header,
  input  logic              in_is_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_is_header,
  output logic              out_is_tail,
  output logic [2:0]        out_port,
  output logic              proto_err,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ID_X_W-1:0] MY_X     = ID_X_W'(X_ID);
  localparam logic [ID_Y_W-1:0] MY_Y     = ID_Y_W'(Y_ID);

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_WEST  = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  logic [FLIT_W+1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              route_en;
  logic              drop;
  logic              tail_pop;
  logic              first_flit;
  logic [FLIT_W+1:0] head;
  logic [ID_X_W-1:0] dx;
  logic [ID_Y_W-1:0] dy;
  port_e             route;
  state_e            state;
  state_e            next_state;

  assign empty         = (count == '0);
  assign full          = (count == FULL_CNT);
  assign in_ready      = !full;
  assign push          = in_valid && !full;
  assign head          = mem[rd_ptr];
  assign out_flit      = head[FLIT_W-1:0];
  assign out_is_header = head[FLIT_W];
  assign out_is_tail   = head[FLIT_W+1];
  assign dx            = out_flit[DST_X_LSB +: ID_X_W];
  assign dy            = out_flit[DST_Y_LSB +: ID_Y_W];

  // X is resolved completely before Y, which keeps the mesh deadlock-free.
  always_comb begin
    route = PORT_LOCAL;
    if (dx > MY_X)      route = PORT_EAST;
    else if (dx < MY_X) route = PORT_WEST;
    else if (dy > MY_Y) route = PORT_NORTH;
    else if (dy < MY_Y) route = PORT_SOUTH;
  end

  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    pop        = 1'b0;
    route_en   = 1'b0;
    drop       = 1'b0;
    tail_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (out_is_header) begin
            route_en   = 1'b1;
            next_state = ACTIVE;
          end else begin
            drop = 1'b1;
            pop  = 1'b1;
          end
        end
      end
      ACTIVE: begin
        out_valid = !empty;
        pop       = out_valid && out_ready;
        tail_pop  = pop && out_is_tail;
        if (tail_pop) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge noc_clk) begin
    if (push) mem[wr_ptr] <= {in_is_tail, in_is_header, in_flit};
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      out_port   <= 3'd0;
      first_flit <= 1'b0;
      proto_err  <= 1'b0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= next_state;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (route_en) begin
        out_port   <= route;
        first_flit <= 1'b1;
      end else if (pop && state == ACTIVE) begin
        first_flit <= 1'b0;
      end
      // A header that is not the routed one means the sender broke framing.
      if (pop && state == ACTIVE && out_is_header && !first_flit) proto_err <= 1'b1;
      if (tail_pop) pkt_cnt <= pkt_cnt + 16'd1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_noc_local_ingress_unit.sv
// Directed bench for noc_local_ingress_unit at router (1,1) with a 4-deep FIFO.
module tb_noc_local_ingress_unit;

  localparam int FLIT_W = 64;

  typedef struct packed {
    logic              hdr;
    logic              tail;
    logic [FLIT_W-1:0] flit;
    logic [2:0]        port;
  } rx_t;

  logic              noc_clk = 1'b0;
  logic              noc_rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FLIT_W-1:0] in_flit = '0;
  logic              in_is_header = 1'b0;
  logic              in_is_tail = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [FLIT_W-1:0] out_flit;
  logic              out_is_header;
  logic              out_is_tail;
  logic [2:0]        out_port;
  logic              proto_err;
  logic [15:0]       pkt_cnt;
  logic [7:0]        drop_cnt;

  int  vectors = 0;
  int  miscompares = 0;
  rx_t rx_q[$];

  noc_local_ingress_unit #(
    .X_ID(1), .Y_ID(1), .FLIT_W(FLIT_W), .ID_X_W(4), .ID_Y_W(4),
    .DST_X_LSB(44), .DST_Y_LSB(40), .DEPTH(4)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .out_port(out_port), .proto_err(proto_err),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  // Inputs only change just after posedge, so a negedge sample sees the handshake.
  always @(negedge noc_clk) begin
    if (noc_rst_n && out_valid && out_ready)
      rx_q.push_back('{out_is_header, out_is_tail, out_flit, out_port});
  end

  function automatic logic [FLIT_W-1:0] hdr(input logic [3:0] dx, input logic [3:0] dy,
                                             input logic [15:0] tag);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[47:44] = dx;
    f[43:40] = dy;
    f[15:0]  = tag;
    return f;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    noc_rst_n = 1'b0;
    wait_cycles(2);
    noc_rst_n = 1'b1;
    rx_q.delete();
  endtask

  task automatic drive(input logic [FLIT_W-1:0] f, input logic h, input logic t);
    in_valid     = 1'b1;
    in_flit      = f;
    in_is_header = h;
    in_is_tail   = t;
  endtask

  task automatic send(input logic [FLIT_W-1:0] f, input logic h, input logic t);
    int guard;
    guard = 0;
    drive(f, h, t);
    while (!in_ready && guard < 100) begin
      wait_cycles(1);
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    wait_cycles(1);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %0b want 1", in_ready); end
    vectors++; if (out_port !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_out_port: got %0d want 0", out_port); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_proto_err: got %0b want 0", proto_err); end
    vectors++; if (pkt_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_route_east();
    logic [FLIT_W-1:0] exp_f [3];
    $display("[TB] test_route_east");
    do_reset();
    out_ready = 1'b1;
    exp_f[0] = hdr(4'd3, 4'd0, 16'hA000);
    exp_f[1] = 64'h1111_0000_0000_A001;
    exp_f[2] = 64'h2222_0000_0000_A002;
    drive(exp_f[0], 1'b1, 1'b0);
    wait_cycles(1);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL east_bubble: out_valid=%0b want 0", out_valid); end
    drive(exp_f[1], 1'b0, 1'b0);
    wait_cycles(1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL east_latency: out_valid=%0b want 1", out_valid); end
    vectors++; if (out_port !== 3'd1) begin miscompares++; $display("[TB] FAIL east_port: got %0d want 1", out_port); end
    send(exp_f[2], 1'b0, 1'b1);
    wait_cycles(4);
    vectors++; if (rx_q.size() !== 3) begin miscompares++; $display("[TB] FAIL east_count: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i].flit !== exp_f[i] || rx_q[i].hdr !== (i == 0) || rx_q[i].tail !== (i == 2) || rx_q[i].port !== 3'd1) begin
        miscompares++;
        $display("[TB] FAIL east_flit%0d: got %h h%0b t%0b p%0d want %h", i, rx_q[i].flit, rx_q[i].hdr, rx_q[i].tail, rx_q[i].port, exp_f[i]);
      end
    end
    vectors++; if (pkt_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL east_pkt_cnt: got %0d want 1", pkt_cnt); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL east_proto_err: got %0b want 0", proto_err); end
  endtask

  task automatic test_routes();
    logic [3:0] dxs [4];
    logic [3:0] dys [4];
    logic [2:0] exp_p [4];
    $display("[TB] test_routes");
    dxs = '{4'd0, 4'd1, 4'd1, 4'd1};
    dys = '{4'd1, 4'd3, 4'd0, 4'd1};
    exp_p = '{3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      send(hdr(dxs[i], dys[i], 16'(i)), 1'b1, 1'b1);
      wait_cycles(4);
      vectors++;
      if (out_port !== exp_p[i]) begin miscompares++; $display("[TB] FAIL route%0d_port: got %0d want %0d", i, out_port, exp_p[i]); end
      vectors++;
      if (rx_q.size() !== 1) begin miscompares++; $display("[TB] FAIL route%0d_count: got %0d want 1", i, rx_q.size()); end
    end
    vectors++; if (pkt_cnt !== 16'd4) begin miscompares++; $display("[TB] FAIL routes_pkt_cnt: got %0d want 4", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [FLIT_W-1:0] exp_f [6];
    $display("[TB] test_back_to_back");
    do_reset();
    exp_f[0] = hdr(4'd1, 4'd3, 16'hB000);
    for (int i = 1; i < 6; i++) exp_f[i] = 64'hB0B0_0000_0000_0000 | 64'(i);
    for (int i = 0; i < 4; i++) send(exp_f[i], i == 0, 1'b0);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full: in_ready=%0b want 0", in_ready); end
    drive(exp_f[4], 1'b0, 1'b0);
    wait_cycles(3);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_hold: in_ready=%0b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b1 || out_flit !== exp_f[0]) begin miscompares++; $display("[TB] FAIL b2b_head: valid=%0b flit=%h want 1 %h", out_valid, out_flit, exp_f[0]); end
    out_ready = 1'b1;
    send(exp_f[4], 1'b0, 1'b0);
    send(exp_f[5], 1'b0, 1'b1);
    wait_cycles(8);
    vectors++; if (rx_q.size() !== 6) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i].flit !== exp_f[i] || rx_q[i].port !== 3'd3) begin
        miscompares++;
        $display("[TB] FAIL b2b_flit%0d: got %h p%0d want %h p3", i, rx_q[i].flit, rx_q[i].port, exp_f[i]);
      end
    end
    vectors++; if (pkt_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL b2b_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_orphans();
    $display("[TB] test_orphans");
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(64'hDEAD_0000_0000_0000 | 64'(i), 1'b0, 1'b0);
    wait_cycles(3);
    vectors++; if (drop_cnt !== 8'd3) begin miscompares++; $display("[TB] FAIL orphan_drop3: got %0d want 3", drop_cnt); end
    vectors++; if (rx_q.size() !== 0) begin miscompares++; $display("[TB] FAIL orphan_fwd: got %0d want 0", rx_q.size()); end
    for (int i = 0; i < 300; i++) send(64'(i), 1'b0, i[0]);
    wait_cycles(3);
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("[TB] FAIL orphan_sat: got %0d want 255", drop_cnt); end
    vectors++; if (pkt_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL orphan_pkt_cnt: got %0d want 0", pkt_cnt); end
  endtask

  task automatic test_proto_err();
    logic [FLIT_W-1:0] exp_f [3];
    $display("[TB] test_proto_err");
    do_reset();
    out_ready = 1'b1;
    exp_f[0] = hdr(4'd3, 4'd0, 16'hC000);
    exp_f[1] = hdr(4'd0, 4'd1, 16'hC001);
    exp_f[2] = 64'hC0C0_0000_0000_C002;
    send(exp_f[0], 1'b1, 1'b0);
    send(exp_f[1], 1'b1, 1'b0);
    send(exp_f[2], 1'b0, 1'b1);
    wait_cycles(5);
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("[TB] FAIL proto_err: got %0b want 1", proto_err); end
    vectors++; if (pkt_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL proto_pkt_cnt: got %0d want 1", pkt_cnt); end
    vectors++; if (rx_q.size() !== 3) begin miscompares++; $display("[TB] FAIL proto_count: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i].flit !== exp_f[i] || rx_q[i].port !== 3'd1) begin
        miscompares++;
        $display("[TB] FAIL proto_flit%0d: got %h p%0d want %h p1", i, rx_q[i].flit, rx_q[i].port, exp_f[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [FLIT_W-1:0] h2;
    logic [FLIT_W-1:0] t2;
    $display("[TB] test_mid_reset");
    do_reset();
    send(hdr(4'd3, 4'd0, 16'hD000), 1'b1, 1'b0);
    send(64'hD0D0_0000_0000_D001, 1'b0, 1'b0);
    wait_cycles(2);
    vectors++; if (out_valid !== 1'b1 || out_port !== 3'd1) begin miscompares++; $display("[TB] FAIL mid_pre: valid=%0b port=%0d want 1 1", out_valid, out_port); end
    noc_rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_out_valid: got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_in_ready: got %0b want 1", in_ready); end
    vectors++; if (out_port !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_out_port: got %0d want 0", out_port); end
    wait_cycles(1);
    noc_rst_n = 1'b1;
    rx_q.delete();
    out_ready = 1'b1;
    h2 = hdr(4'd1, 4'd0, 16'hD100);
    t2 = 64'hD1D1_0000_0000_D101;
    send(h2, 1'b1, 1'b0);
    send(t2, 1'b0, 1'b1);
    wait_cycles(5);
    vectors++; if (out_port !== 3'd4) begin miscompares++; $display("[TB] FAIL mid_route: got %0d want 4", out_port); end
    vectors++; if (pkt_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL mid_pkt_cnt: got %0d want 1", pkt_cnt); end
    vectors++;
    if (rx_q.size() !== 2) begin
      miscompares++; $display("[TB] FAIL mid_count: got %0d want 2", rx_q.size());
    end else if (rx_q[0].flit !== h2 || rx_q[1].flit !== t2) begin
      miscompares++; $display("[TB] FAIL mid_flits: got %h %h want %h %h", rx_q[0].flit, rx_q[1].flit, h2, t2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_route_east();
    test_routes();
    test_back_to_back();
    test_orphans();
    test_proto_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noc_local_ingress_unit.md
Name: noc_local_ingress_unit

Overview:
- Router-side input stage for the local port; consumes the flit stream a node sender produces (header / body / tail with valid-ready).
- Buffers flits in a small FIFO and decodes the destination from each header.
- Computes the dimension-ordered (XY) output port and locks that route for the packet until its tail leaves.
- Presents flits plus the locked port index to the router switch stage. Also keeps packet and drop statistics.

Parameters:
- X_ID, 0, router X coordinate (width ID_X_W)
- Y_ID, 0, router Y coordinate (width ID_Y_W)
- FLIT_W, 64, flit width (matches `Noc_Data_Width)
- ID_X_W, 4, X coordinate width (matches `Noc_ID_X_Width)
- ID_Y_W, 4, Y coordinate width (matches `Noc_ID_Y_Width)
- DST_X_LSB, 44, header bit position of destination X LSB
- DST_Y_LSB, 40, header bit position of destination Y LSB
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  flit offered by node
- in_ready  out  1  FIFO can accept; equals !full
- in_flit  in  FLIT_W  flit payload
- in_is_header  in  1  flit is packet header
- in_is_tail  in  1  flit is packet tail
- out_valid  out  1  flit offered to switch stage
- out_ready  in  1  switch stage accepts
- out_flit  out  FLIT_W  head-of-FIFO flit
- out_is_header  out  1  sideband copied from FIFO
- out_is_tail  out  1  sideband copied from FIFO
- out_port  out  3  locked route: 0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH
- proto_err  out  1  sticky: header seen inside an open packet
- pkt_cnt  out  16  packets forwarded (tail pops), wraps
- drop_cnt  out  8  orphan flits dropped, saturates at 255

Behaviour:
- Reset (async, while noc_rst_n=0): FIFO empty, state IDLE, out_valid=0, out_port=0, proto_err=0, pkt_cnt=0, drop_cnt=0. in_ready=1 once FIFO is empty.
- Push: in_valid && in_ready writes {flit, is_header, is_tail}. When full, in_ready=0 and no push occurs even if a pop happens in the same cycle. Occupancy = count + push - pop.
- Pop: occurs on out_valid && out_ready (ACTIVE), or on a drop (IDLE).
- out_flit, out_is_header and out_is_tail are driven from the FIFO head; their value is don't-care when out_valid=0.
- State IDLE, head empty: wait.
- State IDLE, head non-empty with is_header=1: decode dx = flit[DST_X_LSB+:ID_X_W] and dy = flit[DST_Y_LSB+:ID_Y_W]. Route:
  - dx>X_ID -> EAST
  - dx<X_ID -> WEST
  - else dy>Y_ID -> NORTH
  - else dy<Y_ID -> SOUTH
  - else LOCAL
  Register the result into out_port and go to ACTIVE. No pop in this cycle; out_valid stays 0.
- State IDLE, head non-empty with is_header=0: orphan flit. Pop it, increment drop_cnt (saturating), stay IDLE.
- State ACTIVE: out_valid = !empty. On a pop of a flit with is_tail=1: pkt_cnt+1 (mod 2^16), return to IDLE. out_port holds its value until the next header is routed.
- State ACTIVE, head flit has is_header=1 and is not the first flit of the packet: forward it as a normal flit and set proto_err (cleared only by reset).
- Single-flit packet (is_header=1 and is_tail=1): routed in IDLE; in ACTIVE it pops, counts, and returns to IDLE.
- Latency:
  - Header pushed at edge N is at the head at N+1, route registered at N+2, out_valid=1 from cycle N+2.
  - Body flit pushed at edge N with ACTIVE and FIFO previously empty: out_valid=1 from cycle N+1.
- Throughput: 1 flit/cycle inside a packet; 1 bubble cycle per packet for routing.
- out_valid, once high, stays high with the same flit until accepted, since the head is stable.
- Reset asserted mid-packet: everything returns to reset values immediately; partial packet discarded.

Test Plan:
- X_ID=1,Y_ID=1; push header dx=3,dy=0, one body, tail with out_ready=1 -> out_port=1 (EAST); out_valid rises 2 cycles after header push; 3 flits out in order; pkt_cnt=1.
- Headers (dx,dy) = (0,1), (1,3), (1,0), (1,1) -> out_port 2, 3, 4, 0 respectively.
- DEPTH=4, out_ready=0, push 6 flits back-to-back -> in_ready low after 4th push; entries 5–6 held at source; release out_ready -> all 6 flits delivered in order.
- Push 3 body flits with no header while IDLE -> none forwarded, drop_cnt=3. Repeat with 300 orphans -> drop_cnt=255.
- Header, then a second header, then tail -> all three forwarded under the first route; proto_err=1; pkt_cnt=1.
- Assert noc_rst_n=0 after header and one body flit are accepted -> out_valid=0 and FIFO empty immediately; the next full packet routes correctly with pkt_cnt=1.
